// File: rtl/onehot_monitor_if.sv
// Bus bundle for onehot_monitor: sample/mode/clear inputs and the registered result and error outputs.
interface onehot_monitor_if #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 8
);
  logic                              in_valid;
  logic [DATA_WIDTH-1:0]             data_in;
  logic [1:0]                        mode;
  logic                              clr;
  logic                              out_valid;
  logic                              is_legal;
  logic [$clog2(DATA_WIDTH)-1:0]     pos;
  logic [$clog2(DATA_WIDTH+1)-1:0]   ones;
  logic [CNT_WIDTH-1:0]              err_count;
  logic                              err_sticky;
  logic [DATA_WIDTH-1:0]             first_err_data;

  modport master (
    output in_valid, data_in, mode, clr,
    input  out_valid, is_legal, pos, ones, err_count, err_sticky, first_err_data
  );

  modport slave (
    input  in_valid, data_in, mode, clr,
    output out_valid, is_legal, pos, ones, err_count, err_sticky, first_err_data
  );
endinterface

// File: rtl/onehot_monitor.sv
// Registered one-hot / one-hot-or-zero / one-cold legality monitor with
// position, popcount, saturating violation counter and first-error capture.
module onehot_monitor #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  onehot_monitor_if.slave  mon
);
  localparam int PW = $clog2(DATA_WIDTH);
  localparam int OW = $clog2(DATA_WIDTH + 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  function automatic logic [OW-1:0] popcount(input logic [DATA_WIDTH-1:0] w);
    logic [OW-1:0] c;
    c = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      c = c + OW'(w[i]);
    end
    return c;
  endfunction

  // Scans downward so the lowest set index is the one left standing.
  function automatic logic [PW-1:0] lowest_set(input logic [DATA_WIDTH-1:0] w);
    logic [PW-1:0] p;
    p = '0;
    for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
      p = w[i] ? PW'(i) : p;
    end
    return p;
  endfunction

  logic [OW-1:0]         ones_s;
  logic [PW-1:0]         pos_s;
  logic                  legal_s;
  logic                  violation_s;

  logic                  out_valid_r;
  logic                  is_legal_r;
  logic [PW-1:0]         pos_r;
  logic [OW-1:0]         ones_r;
  logic [CNT_WIDTH-1:0]  err_count_r;
  logic                  err_sticky_r;
  logic [DATA_WIDTH-1:0] first_err_data_r;

  // Classify the incoming word under the requested mode.
  always_comb begin
    ones_s  = popcount(mon.data_in);
    pos_s   = lowest_set(mon.data_in);
    legal_s = 1'b0;
    case (mon.mode)
      2'd0: legal_s = (ones_s == OW'(1));
      2'd1: legal_s = (ones_s <= OW'(1));
      2'd2: begin
        legal_s = (ones_s == OW'(DATA_WIDTH - 1));
        pos_s   = lowest_set(~mon.data_in);
      end
      2'd3: legal_s = (ones_s == OW'(1));
      default: legal_s = (ones_s == OW'(1));
    endcase
    violation_s = mon.in_valid & ~legal_s;
  end

  // Result registers plus error bookkeeping; clr outranks a coincident violation.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_r      <= 1'b0;
      is_legal_r       <= 1'b0;
      pos_r            <= '0;
      ones_r           <= '0;
      err_count_r      <= '0;
      err_sticky_r     <= 1'b0;
      first_err_data_r <= '0;
    end else begin
      out_valid_r <= mon.in_valid;
      if (mon.in_valid) begin
        is_legal_r <= legal_s;
        pos_r      <= pos_s;
        ones_r     <= ones_s;
      end
      if (mon.clr) begin
        err_count_r      <= '0;
        err_sticky_r     <= 1'b0;
        first_err_data_r <= '0;
      end else if (violation_s) begin
        if (err_count_r != CNT_MAX) begin
          err_count_r <= err_count_r + CNT_WIDTH'(1);
        end
        err_sticky_r <= 1'b1;
        if (!err_sticky_r) begin
          first_err_data_r <= mon.data_in;
        end
      end
    end
  end

  assign mon.out_valid      = out_valid_r;
  assign mon.is_legal       = is_legal_r;
  assign mon.pos            = pos_r;
  assign mon.ones           = ones_r;
  assign mon.err_count      = err_count_r;
  assign mon.err_sticky     = err_sticky_r;
  assign mon.first_err_data = first_err_data_r;
endmodule

// File: tb/tb_onehot_monitor.sv
// Directed bench for onehot_monitor: a vector table plus hand sequences for
// error bookkeeping, counter saturation (CNT_WIDTH=2 instance), clr priority and reset.
module tb_onehot_monitor;
  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  onehot_monitor_if #(.DATA_WIDTH(8), .CNT_WIDTH(8)) bus8 ();
  onehot_monitor_if #(.DATA_WIDTH(8), .CNT_WIDTH(2)) bus2 ();

  onehot_monitor #(.DATA_WIDTH(8), .CNT_WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .mon(bus8));
  onehot_monitor #(.DATA_WIDTH(8), .CNT_WIDTH(2)) dut2 (.clk(clk), .rst_n(rst_n), .mon(bus2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] mode;
    logic [7:0] data;
    logic       exp_legal;
    logic [2:0] exp_pos;
    logic [3:0] exp_ones;
  } vec_t;

  vec_t tbl[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [1:0] m, input logic [7:0] d, input logic c);
    bus8.in_valid = v; bus8.mode = m; bus8.data_in = d; bus8.clr = c;
    bus2.in_valid = v; bus2.mode = m; bus2.data_in = d; bus2.clr = c;
  endtask

  // One clock edge, then sample 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_res(input string name, input logic v, input logic l, input logic [2:0] p, input logic [3:0] o);
    chk({name, ".out_valid"}, 32'(bus8.out_valid), 32'(v));
    chk({name, ".is_legal"},  32'(bus8.is_legal),  32'(l));
    chk({name, ".pos"},       32'(bus8.pos),       32'(p));
    chk({name, ".ones"},      32'(bus8.ones),      32'(o));
  endtask

  task automatic chk_err(input string name, input logic [7:0] cnt, input logic st, input logic [7:0] first);
    chk({name, ".err_count"},      32'(bus8.err_count),      32'(cnt));
    chk({name, ".err_sticky"},     32'(bus8.err_sticky),     32'(st));
    chk({name, ".first_err_data"}, 32'(bus8.first_err_data), 32'(first));
  endtask

  initial begin
    total = 0;
    bad   = 0;
    tbl[0]  = '{2'd0, 8'h10, 1'b1, 3'd4, 4'd1};
    tbl[1]  = '{2'd0, 8'h00, 1'b0, 3'd0, 4'd0};
    tbl[2]  = '{2'd0, 8'hFF, 1'b0, 3'd0, 4'd8};
    tbl[3]  = '{2'd0, 8'h80, 1'b1, 3'd7, 4'd1};
    tbl[4]  = '{2'd1, 8'h00, 1'b1, 3'd0, 4'd0};
    tbl[5]  = '{2'd1, 8'h80, 1'b1, 3'd7, 4'd1};
    tbl[6]  = '{2'd1, 8'h05, 1'b0, 3'd0, 4'd2};
    tbl[7]  = '{2'd2, 8'hF7, 1'b1, 3'd3, 4'd7};
    tbl[8]  = '{2'd2, 8'hFF, 1'b0, 3'd0, 4'd8};
    tbl[9]  = '{2'd2, 8'h7F, 1'b1, 3'd7, 4'd7};
    tbl[10] = '{2'd2, 8'hFE, 1'b1, 3'd0, 4'd7};
    tbl[11] = '{2'd2, 8'h0C, 1'b0, 3'd0, 4'd2};
    tbl[12] = '{2'd3, 8'h20, 1'b1, 3'd5, 4'd1};
    tbl[13] = '{2'd3, 8'h00, 1'b0, 3'd0, 4'd0};

    // Reset state
    rst_n = 1'b0;
    drive(1'b0, 2'd0, 8'h00, 1'b0);
    tick(); tick();
    chk_res("reset", 1'b0, 1'b0, 3'd0, 4'd0);
    chk_err("reset", 8'd0, 1'b0, 8'h00);
    chk("reset.cnt2", 32'(bus2.err_count), 32'd0);
    rst_n = 1'b1;

    // Legal strict one-hot, then idle holds result fields
    drive(1'b1, 2'd0, 8'h10, 1'b0); tick();
    chk_res("oh10", 1'b1, 1'b1, 3'd4, 4'd1);
    chk_err("oh10", 8'd0, 1'b0, 8'h00);
    drive(1'b0, 2'd0, 8'h00, 1'b0); tick();
    chk_res("idle", 1'b0, 1'b1, 3'd4, 4'd1);

    // Zero word: illegal in mode 0, legal in mode 1
    drive(1'b1, 2'd0, 8'h00, 1'b0); tick();
    chk_res("zero_m0", 1'b1, 1'b0, 3'd0, 4'd0);
    chk_err("zero_m0", 8'd1, 1'b1, 8'h00);
    drive(1'b1, 2'd1, 8'h00, 1'b0); tick();
    chk_res("zero_m1", 1'b1, 1'b1, 3'd0, 4'd0);
    chk_err("zero_m1", 8'd1, 1'b1, 8'h00);

    drive(1'b0, 2'd0, 8'h00, 1'b1); tick();
    chk_err("clr1", 8'd0, 1'b0, 8'h00);

    // Back-to-back: first error captured, not overwritten
    drive(1'b1, 2'd0, 8'h03, 1'b0); tick();
    chk_res("b2b_03", 1'b1, 1'b0, 3'd0, 4'd2);
    drive(1'b1, 2'd0, 8'h81, 1'b0); tick();
    chk_res("b2b_81", 1'b1, 1'b0, 3'd0, 4'd2);
    chk_err("b2b_81", 8'd2, 1'b1, 8'h03);
    drive(1'b1, 2'd0, 8'h40, 1'b0); tick();
    chk_res("b2b_40", 1'b1, 1'b1, 3'd6, 4'd1);
    chk_err("b2b_40", 8'd2, 1'b1, 8'h03);

    // Vector table
    for (int i = 0; i < 14; i++) begin
      drive(1'b1, tbl[i].mode, tbl[i].data, 1'b0);
      tick();
      chk_res($sformatf("tbl%0d", i), 1'b1, tbl[i].exp_legal, tbl[i].exp_pos, tbl[i].exp_ones);
    end

    drive(1'b0, 2'd0, 8'h00, 1'b1); tick();
    chk_err("clr2", 8'd0, 1'b0, 8'h00);
    chk("clr2.cnt2", 32'(bus2.err_count), 32'd0);

    // Saturation: 2-bit counter stops at 3
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 2'd0, 8'h00, 1'b0);
      tick();
      chk($sformatf("sat%0d.cnt2", i), 32'(bus2.err_count), (i < 3) ? 32'(i + 1) : 32'd3);
      chk($sformatf("sat%0d.cnt8", i), 32'(bus8.err_count), 32'(i + 1));
    end

    drive(1'b0, 2'd0, 8'h00, 1'b1); tick();
    chk_err("clr3", 8'd0, 1'b0, 8'h00);

    // clr wins over a coincident violation; result still produced
    drive(1'b1, 2'd0, 8'h03, 1'b1); tick();
    chk_res("clr_viol", 1'b1, 1'b0, 3'd0, 4'd2);
    chk_err("clr_viol", 8'd0, 1'b0, 8'h00);
    drive(1'b1, 2'd1, 8'h0C, 1'b0); tick();
    chk_res("after_clr", 1'b1, 1'b0, 3'd2, 4'd2);
    chk_err("after_clr", 8'd1, 1'b1, 8'h0C);

    // Mid-stream reset drops the in-flight sample
    drive(1'b1, 2'd0, 8'h10, 1'b0);
    rst_n = 1'b0; tick();
    chk_res("midrst", 1'b0, 1'b0, 3'd0, 4'd0);
    chk_err("midrst", 8'd0, 1'b0, 8'h00);
    rst_n = 1'b1;
    drive(1'b0, 2'd0, 8'h00, 1'b0); tick();
    chk("post_rst.out_valid", 32'(bus8.out_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/onehot_monitor.md
Name: onehot_monitor

Overview:
- Registered, parametrised one-hot legality monitor for status and select buses.
- Classifies each valid input word under a selectable mode and reports position and popcount one cycle later.
- Keeps a saturating violation counter, a sticky error flag and a capture of the first offending word.
- Instantiated on arbiter-grant and FSM-state buses as a runtime checker. Results feed a status register block.

Parameters:
DATA_WIDTH, 8, width of monitored word; must be >= 2
CNT_WIDTH, 8, width of saturating violation counter; must be >= 1

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  synchronous active-low reset
in_valid  input  1  data_in/mode sampled this cycle
data_in  input  DATA_WIDTH  word under check
mode  input  2  0 strict one-hot, 1 one-hot-or-zero, 2 one-cold, 3 reserved (treated as 0)
clr  input  1  synchronous clear of err_count, err_sticky, first_err_data
out_valid  output  1  result outputs valid this cycle
is_legal  output  1  sampled word legal under sampled mode
pos  output  $clog2(DATA_WIDTH)  index of lowest set bit (modes 0/1) or lowest clear bit (mode 2); 0 if none
ones  output  $clog2(DATA_WIDTH+1)  popcount of sampled word
err_count  output  CNT_WIDTH  number of illegal samples, saturating
err_sticky  output  1  set on first illegal sample, held until clr/reset
first_err_data  output  DATA_WIDTH  data_in of first illegal sample since reset/clr

Behaviour:
- Reset (rst_n low at clk edge): all outputs 0. Reset mid-stream discards the in-flight sample; out_valid is 0 on the first edge after release.
- Latency: exactly 1 cycle. Sample at edge N with in_valid=1 gives out_valid=1, with is_legal/pos/ones for that sample, after edge N.
- in_valid=0: out_valid=0 next cycle. is_legal/pos/ones hold their last values.
- Legality rules:
  - mode 0: ones==1.
  - mode 1: ones<=1.
  - mode 2: ones==DATA_WIDTH-1.
  - mode 3: same as mode 0.
- pos:
  - Modes 0/1/3: lowest index i with data_in[i]=1.
  - Mode 2: lowest index with data_in[i]=0.
  - No such bit: pos=0.
  - pos is reported even when is_legal=0.
- Violation (in_valid=1 and illegal):
  - err_count increments by 1 at the same edge as the result registers; it stays at 2^CNT_WIDTH-1 once saturated.
  - err_sticky is set.
  - first_err_data is loaded only if err_sticky was 0 before the edge.
- clr=1:
  - At the edge, err_count=0, err_sticky=0, first_err_data=0.
  - clr has priority over a simultaneous violation: that sample is not counted or captured. Its out_valid/is_legal/pos/ones are still produced normally.
- No backpressure: the monitor accepts one sample per cycle with no stall.
- The checking path is combinational popcount/priority logic feeding the output registers. No multicycle paths.

Test Plan:
- DATA_WIDTH=8, mode 0, data_in=8'b0001_0000 for one cycle -> next cycle out_valid=1, is_legal=1, pos=4, ones=1; err_count=0.
- mode 0, data_in=8'b0000_0000 then mode 1, data_in=8'b0000_0000 -> is_legal=0 then 1, both pos=0; err_count=1, err_sticky=1, first_err_data=8'h00.
- mode 0, back-to-back 8'h03, 8'h81, 8'h40 -> is_legal 0,0,1; pos 0,0,6; ones 2,2,1; err_count=2; first_err_data=8'h03, not overwritten by 8'h81.
- mode 2, data_in=8'b1111_0111 -> is_legal=1, pos=3, ones=7; then 8'hFF -> is_legal=0, pos=0, ones=8.
- CNT_WIDTH=2: five consecutive illegal samples -> err_count 1,2,3,3,3.
- Illegal sample with clr=1 in the same cycle -> result outputs valid with is_legal=0, but err_count=0, err_sticky=0. rst_n=0 for one edge mid-stream -> all outputs 0 and out_valid=0 on the next cycle.
